// File: rtl/axil_cmd_pkg.sv
// Shared state type, field positions and response codes for the stream-driven
// AXI-Lite command master.
`timescale 1ns/1ps
package axil_cmd_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StWdata,
        StDrain,
        StAxiW,
        StBWait,
        StAr,
        StRWait,
        StRspStat,
        StRspData
    } state_e;

    // Command header fields
    localparam int unsigned RW_BIT = 31;

    // Status beat layout
    localparam int unsigned MALFORMED_BIT = 3;
    localparam int unsigned RESP_LSB      = 0;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // A malformed command always reports SLVERR regardless of the captured resp.
    function automatic logic [31:0] pack_status(input logic       rw,
                                                input logic       malformed,
                                                input logic [1:0] resp);
        logic [31:0] word;
        word                = '0;
        word[RW_BIT]        = rw;
        word[MALFORMED_BIT] = malformed;
        word[RESP_LSB +: 2] = malformed ? SLVERR : resp;
        return word;
    endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// Turns command packets on an AXI-Stream input into single AXI-Lite reads/writes
// and returns a status beat (plus read data) on an AXI-Stream output.
`timescale 1ns/1ps
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned ID_WIDTH   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ID_WIDTH-1:0]   s_tid,
    input  logic [31:0]           s_tdata,
    input  logic                  s_tlast,
    input  logic [3:0]            s_tkeep,
    input  logic                  s_tvalid,
    output logic                  s_tready,

    output logic [ID_WIDTH-1:0]   m_tid,
    output logic [31:0]           m_tdata,
    output logic                  m_tlast,
    output logic [3:0]            m_tkeep,
    output logic                  m_tvalid,
    input  logic                  m_tready,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,

    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,

    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [31:0]           m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_e                state_q, state_d;
    logic                  s_tready_q, s_tready_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            resp_q, resp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  malformed_q, malformed_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic [31:0]           m_tdata_q, m_tdata_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [3:0]            m_tkeep_q, m_tkeep_d;
    logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;

    logic s_hs, aw_hs, w_hs, ar_hs, m_hs;
    logic rd_ok;

    assign s_hs  = s_tvalid && s_tready_q;
    assign aw_hs = awvalid_q && m_axil_awready;
    assign w_hs  = wvalid_q && m_axil_wready;
    assign ar_hs = arvalid_q && m_axil_arready;
    assign m_hs  = m_tvalid_q && m_tready;
    assign rd_ok = !rw_q && !malformed_q;

    always_comb begin
        state_d     = state_q;
        tid_d       = tid_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        resp_d      = resp_q;
        rdata_d     = rdata_q;
        malformed_d = malformed_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        m_tvalid_d  = m_tvalid_q;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        m_tkeep_d   = m_tkeep_q;
        m_tid_d     = m_tid_q;

        case (state_q)
            StIdle: begin
                if (s_hs) begin
                    tid_d       = s_tid;
                    rw_d        = s_tdata[RW_BIT];
                    addr_d      = s_tdata[ADDR_WIDTH-1:0];
                    resp_d      = OKAY;
                    malformed_d = 1'b0;
                    if (s_tdata[RW_BIT]) begin
                        if (s_tlast) begin
                            malformed_d = 1'b1;
                            state_d     = StRspStat;
                        end else begin
                            state_d = StWdata;
                        end
                    end else begin
                        if (s_tlast) begin
                            state_d = StAr;
                        end else begin
                            malformed_d = 1'b1;
                            state_d     = StDrain;
                        end
                    end
                end
            end

            StWdata: begin
                if (s_hs) begin
                    wdata_d = s_tdata;
                    wstrb_d = s_tkeep;
                    if (s_tlast) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StAxiW;
                    end else begin
                        malformed_d = 1'b1;
                        state_d     = StDrain;
                    end
                end
            end

            StDrain: begin
                if (s_hs && s_tlast) begin
                    state_d = StRspStat;
                end
            end

            // Valids come up one cycle after entry and each drops on its own handshake.
            StAxiW: begin
                awvalid_d = !aw_done_q && !aw_hs;
                wvalid_d  = !w_done_q && !w_hs;
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = StBWait;
                end
            end

            StBWait: begin
                if (m_axil_bvalid) begin
                    resp_d  = m_axil_bresp;
                    state_d = StRspStat;
                end
            end

            StAr: begin
                arvalid_d = !ar_hs;
                if (ar_hs) begin
                    state_d = StRWait;
                end
            end

            StRWait: begin
                if (m_axil_rvalid) begin
                    rdata_d = m_axil_rdata;
                    resp_d  = m_axil_rresp;
                    state_d = StRspStat;
                end
            end

            StRspStat: begin
                if (!m_tvalid_q) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = pack_status(rw_q, malformed_q, resp_q);
                    m_tlast_d  = !rd_ok;
                    m_tkeep_d  = 4'hF;
                    m_tid_d    = tid_q;
                end else if (m_hs) begin
                    if (rd_ok) begin
                        m_tdata_d = rdata_q;
                        m_tlast_d = 1'b1;
                        state_d   = StRspData;
                    end else begin
                        m_tvalid_d = 1'b0;
                        state_d    = StIdle;
                    end
                end
            end

            StRspData: begin
                if (m_hs) begin
                    m_tvalid_d = 1'b0;
                    state_d    = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Registered so that it is low throughout reset and tracks the next state.
    assign s_tready_d = (state_d == StIdle) || (state_d == StWdata) || (state_d == StDrain);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            s_tready_q  <= 1'b0;
            tid_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            resp_q      <= OKAY;
            rdata_q     <= '0;
            malformed_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tlast_q   <= 1'b0;
            m_tkeep_q   <= '0;
            m_tid_q     <= '0;
        end else begin
            state_q     <= state_d;
            s_tready_q  <= s_tready_d;
            tid_q       <= tid_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            malformed_q <= malformed_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            m_tlast_q   <= m_tlast_d;
            m_tkeep_q   <= m_tkeep_d;
            m_tid_q     <= m_tid_d;
        end
    end

    assign s_tready       = s_tready_q;
    assign m_tid          = m_tid_q;
    assign m_tdata        = m_tdata_q;
    assign m_tlast        = m_tlast_q;
    assign m_tkeep        = m_tkeep_q;
    assign m_tvalid       = m_tvalid_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = (state_q == StBWait);
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = (state_q == StRWait);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a reactive AXI-Lite slave and response
// sink on the falling edge, command stimulus just after the rising edge.
`timescale 1ns/1ps
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [0:0]  s_tid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic [0:0]  m_tid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic [6:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [6:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    axil_cmd_master #(.ADDR_WIDTH(7), .ID_WIDTH(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_tid(s_tid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tid(m_tid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave configuration and monitor state
    int          aw_delay = 0, w_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          m_hold = 0;
    int          cyc = 0;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs, s_acc, busy_acc, viol, bp_cycles;
    int          aw_tot = 0, w_tot = 0, b_sent = 0;
    int          aw_wait = 0, w_wait = 0;
    int          last_s_cyc = 0, lat = 0;
    logic [31:0] cap_awaddr, cap_wdata, cap_wstrb, cap_araddr;
    logic        b_owe, r_owe, b_fire, r_fire, aw_fire, w_fire, ar_fire, m_fire;
    logic        p_aw, p_w, p_ar, p_m, p_mvalid;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_mdata;
    logic [3:0]  p_wstrb;
    logic        p_mlast;
    logic [31:0] rsp_data[$];
    logic        rsp_last[$];
    logic [0:0]  rsp_tid[$];
    logic [3:0]  rsp_keep[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset_n) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; m_tready = 0;
            bresp = 0; rresp = 0; rdata = 0;
            b_owe = 0; r_owe = 0; b_fire = 0; r_fire = 0;
            p_aw = 0; p_w = 0; p_ar = 0; p_m = 0; p_mvalid = 0;
            aw_wait = 0; w_wait = 0;
        end else begin
            if (b_fire) bvalid = 0;
            if (r_fire) rvalid = 0;
            if (b_owe) begin bvalid = 1; bresp = cfg_bresp; b_owe = 0; end
            if (r_owe) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; r_owe = 0; end
            awready = awvalid && (aw_wait >= aw_delay);
            wready  = wvalid && (w_wait >= w_delay);
            arready = arvalid;
            if (m_tvalid && m_hold > 0) begin
                m_tready = 0; m_hold--; bp_cycles++;
            end else begin
                m_tready = 1;
            end
            // Values are stable until the next rising edge, so these predict its handshakes.
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            ar_fire = arvalid && arready;
            b_fire  = bvalid && bready;
            r_fire  = rvalid && rready;
            m_fire  = m_tvalid && m_tready;
            aw_wait = (awvalid && !aw_fire) ? aw_wait + 1 : 0;
            w_wait  = (wvalid && !w_fire) ? w_wait + 1 : 0;

            if (p_aw && (!awvalid || awaddr != p_awaddr[6:0])) viol++;
            if (p_w && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) viol++;
            if (p_ar && (!arvalid || araddr != p_araddr[6:0])) viol++;
            if (p_m && (!m_tvalid || m_tdata != p_mdata || m_tlast != p_mlast)) viol++;
            if (awprot != 3'b000 || arprot != 3'b000) viol++;
            p_aw = awvalid && !aw_fire;  p_awaddr = {25'b0, awaddr};
            p_w  = wvalid && !w_fire;    p_wdata = wdata; p_wstrb = wstrb;
            p_ar = arvalid && !ar_fire;  p_araddr = {25'b0, araddr};
            p_m  = m_tvalid && !m_fire;  p_mdata = m_tdata; p_mlast = m_tlast;

            if (aw_fire) begin aw_hs++; aw_tot++; cap_awaddr = {25'b0, awaddr}; end
            if (w_fire) begin w_hs++; w_tot++; cap_wdata = wdata; cap_wstrb = {28'b0, wstrb}; end
            if (aw_tot > b_sent && w_tot > b_sent) begin b_owe = 1; b_sent++; end
            if (ar_fire) begin ar_hs++; cap_araddr = {25'b0, araddr}; r_owe = 1; end
            if (b_fire) b_hs++;
            if (r_fire) r_hs++;
            if (s_tvalid && s_tready) begin
                s_acc++;
                last_s_cyc = cyc + 1;
                if (m_tvalid) busy_acc++;
            end
            if (m_tvalid && !p_mvalid) lat = cyc - last_s_cyc;
            p_mvalid = m_tvalid;
            if (m_fire) begin
                rsp_data.push_back(m_tdata);
                rsp_last.push_back(m_tlast);
                rsp_tid.push_back(m_tid);
                rsp_keep.push_back(m_tkeep);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        s_acc = 0; busy_acc = 0; viol = 0; bp_cycles = 0;
        rsp_data.delete(); rsp_last.delete(); rsp_tid.delete(); rsp_keep.delete();
    endtask

    task automatic send_beat(input logic tid, input logic [31:0] data, input logic [3:0] keep,
                             input logic last);
        int n;
        s_tvalid = 1; s_tid = tid; s_tdata = data; s_tkeep = keep; s_tlast = last;
        n = 0;
        while (!s_tready && n < 300) begin
            tick();
            n++;
        end
        if (!s_tready) check_eq("s_tready_timeout", {31'b0, s_tready}, 32'd1);
        tick();
        s_tvalid = 0;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 300 && rsp_data.size() < n; i++) tick();
        check_eq("rsp_count", rsp_data.size(), n);
        repeat (3) tick();
    endtask

    task automatic do_write(input logic tid, input logic [31:0] hdr, input logic [31:0] d,
                            input logic [3:0] strb);
        send_beat(tid, hdr, 4'h0, 1'b0);
        send_beat(tid, d, strb, 1'b1);
    endtask

    task automatic check_write_order(input string tag);
        wait_rsp(1);
        check_eq({tag, "_aw"}, aw_hs, 1);
        check_eq({tag, "_w"}, w_hs, 1);
        check_eq({tag, "_b"}, b_hs, 1);
        check_eq({tag, "_stable"}, viol, 0);
        if (rsp_data.size() >= 1) check_eq({tag, "_stat"}, rsp_data[0], 32'h8000_0000);
    endtask

    initial begin
        reset_n = 0; s_tvalid = 0; s_tid = 0; s_tdata = 0; s_tlast = 0; s_tkeep = 0;
        clear_mon();
        repeat (3) tick();
        check_eq("rst_s_tready", {31'b0, s_tready}, 0);
        check_eq("rst_valids", {26'b0, m_tvalid, awvalid, wvalid, arvalid, bready, rready}, 0);
        check_eq("rst_m_tdata", m_tdata, 0);
        check_eq("rst_m_tkeep", {28'b0, m_tkeep}, 0);
        check_eq("rst_aw_ar", {18'b0, awaddr, araddr}, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_wstrb", {28'b0, wstrb}, 0);
        reset_n = 1;
        tick();
        check_eq("idle_s_tready", {31'b0, s_tready}, 1);

        // Basic write; ignored header bits must not leak into the address.
        clear_mon();
        do_write(1'b1, 32'h8ABC_DE14, 32'hDEAD_BEEF, 4'hF);
        wait_rsp(1);
        check_eq("wr_aw_hs", aw_hs, 1);
        check_eq("wr_awaddr", cap_awaddr, 32'h14);
        check_eq("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        check_eq("wr_wstrb", cap_wstrb, 32'hF);
        check_eq("wr_b_hs", b_hs, 1);
        check_eq("wr_latency", lat, 4);
        if (rsp_data.size() >= 1) begin
            check_eq("wr_stat", rsp_data[0], 32'h8000_0000);
            check_eq("wr_last", {31'b0, rsp_last[0]}, 1);
            check_eq("wr_tid", {31'b0, rsp_tid[0]}, 1);
            check_eq("wr_keep", {28'b0, rsp_keep[0]}, 32'hF);
        end

        // Basic read
        clear_mon();
        cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
        send_beat(1'b0, 32'h0000_0020, 4'h0, 1'b1);
        wait_rsp(2);
        check_eq("rd_ar_hs", ar_hs, 1);
        check_eq("rd_araddr", cap_araddr, 32'h20);
        check_eq("rd_no_aw", aw_hs, 0);
        check_eq("rd_latency", lat, 4);
        if (rsp_data.size() >= 2) begin
            check_eq("rd_stat", rsp_data[0], 32'h0000_0000);
            check_eq("rd_stat_last", {31'b0, rsp_last[0]}, 0);
            check_eq("rd_data", rsp_data[1], 32'h1234_5678);
            check_eq("rd_data_last", {31'b0, rsp_last[1]}, 1);
            check_eq("rd_tid", {31'b0, rsp_tid[1]}, 0);
        end

        // AW/W handshake orderings
        clear_mon(); aw_delay = 0; w_delay = 3;
        do_write(1'b0, 32'h8000_0004, 32'h0000_0011, 4'h3);
        check_write_order("aw_first");
        clear_mon(); aw_delay = 3; w_delay = 0;
        do_write(1'b0, 32'h8000_0008, 32'h0000_0022, 4'hC);
        check_write_order("w_first");
        clear_mon(); aw_delay = 2; w_delay = 2;
        do_write(1'b0, 32'h8000_000C, 32'h0000_0033, 4'h1);
        check_write_order("same_cycle");
        aw_delay = 0; w_delay = 0;

        // Malformed: write header with tlast
        clear_mon();
        send_beat(1'b1, 32'h8000_0010, 4'hF, 1'b1);
        wait_rsp(1);
        check_eq("mf_wr_axi", aw_hs + w_hs + ar_hs, 0);
        if (rsp_data.size() >= 1) begin
            check_eq("mf_wr_stat", rsp_data[0], 32'h8000_000A);
            check_eq("mf_wr_last", {31'b0, rsp_last[0]}, 1);
        end

        // Malformed: read header followed by two extra beats
        clear_mon();
        send_beat(1'b0, 32'h0000_0030, 4'hF, 1'b0);
        send_beat(1'b0, 32'h5555_5555, 4'hF, 1'b0);
        send_beat(1'b0, 32'hAAAA_AAAA, 4'hF, 1'b1);
        wait_rsp(1);
        check_eq("mf_rd_beats", s_acc, 3);
        check_eq("mf_rd_axi", aw_hs + w_hs + ar_hs, 0);
        if (rsp_data.size() >= 1) begin
            check_eq("mf_rd_stat", rsp_data[0], 32'h0000_000A);
            check_eq("mf_rd_last", {31'b0, rsp_last[0]}, 1);
        end

        // Backpressure with a second command queued behind the read
        clear_mon();
        cfg_rdata = 32'hCAFE_F00D; m_hold = 5;
        send_beat(1'b0, 32'h0000_0021, 4'h0, 1'b1);
        send_beat(1'b1, 32'h8000_0005, 4'hF, 1'b1);
        wait_rsp(3);
        check_eq("bp_cycles", bp_cycles, 5);
        check_eq("bp_stable", viol, 0);
        check_eq("bp_no_accept", busy_acc, 0);
        if (rsp_data.size() >= 3) begin
            check_eq("bp_stat", rsp_data[0], 32'h0000_0000);
            check_eq("bp_data", rsp_data[1], 32'hCAFE_F00D);
            check_eq("bp_next", rsp_data[2], 32'h8000_000A);
            check_eq("bp_next_tid", {31'b0, rsp_tid[2]}, 1);
        end

        // Slave errors
        clear_mon(); cfg_bresp = 2'b10;
        do_write(1'b1, 32'h8000_0018, 32'h0BAD_0BAD, 4'hF);
        wait_rsp(1);
        if (rsp_data.size() >= 1) check_eq("slverr_wr", rsp_data[0], 32'h8000_0002);
        cfg_bresp = 2'b00;
        clear_mon(); cfg_rresp = 2'b10; cfg_rdata = 32'h0000_BEEF;
        send_beat(1'b0, 32'h0000_001C, 4'h0, 1'b1);
        wait_rsp(2);
        if (rsp_data.size() >= 2) begin
            check_eq("slverr_rd", rsp_data[0], 32'h0000_0002);
            check_eq("slverr_rd_data", rsp_data[1], 32'h0000_BEEF);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
